// File: rtl/fruit_spawner_if.sv
// Launch-control bundle between the game logic (master) and fruit_spawner (slave).
interface fruit_spawner_if;
  logic              enable;
  logic [7:0]        fruits_cut;
  logic              fruit_busy;
  logic              new_fruit;
  logic [9:0]        spawn_x;
  logic signed [9:0] spawn_vx;
  logic signed [9:0] spawn_vy;
  logic [7:0]        spawn_count;

  modport master (
    output enable, fruits_cut, fruit_busy,
    input  new_fruit, spawn_x, spawn_vx, spawn_vy, spawn_count
  );

  modport slave (
    input  enable, fruits_cut, fruit_busy,
    output new_fruit, spawn_x, spawn_vx, spawn_vy, spawn_count
  );
endinterface

// File: rtl/fruit_spawner.sv
// Paced fruit launcher: LFSR-randomised launch position/velocity, difficulty-scaled interval.
// Optional FRUIT_SPAWN_DIFFICULTY_EN shortens the interval as fruits_cut grows.
module fruit_spawner #(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          BASE_INTERVAL = 60,
  parameter int          MIN_INTERVAL  = 15
) (
  input  logic           frame_clk,
  input  logic           Reset,
  fruit_spawner_if.slave spawn
);
  localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  BASE_I    = BASE_INTERVAL[7:0];
  localparam logic [7:0]  FLOOR_I   = MIN_INTERVAL[7:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_LAUNCH} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [7:0]        interval;
  logic [15:0]       lfsr;
  logic              launch;
  logic [9:0]        x_new;
  logic [9:0]        vx_mag;
  logic signed [9:0] vx_new;
  logic signed [9:0] vy_new;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef FRUIT_SPAWN_DIFFICULTY_EN
  // Compare in 10 bits so large cut counts clamp to the floor instead of wrapping.
  function automatic logic [7:0] launch_interval(input logic [7:0] cut);
    logic [9:0] cut2;
    cut2 = {1'b0, cut, 1'b0};
    if ({2'b00, BASE_I} < cut2 + {2'b00, FLOOR_I})
      return FLOOR_I;
    else
      return BASE_I - cut2[7:0];
  endfunction

  always_comb interval = launch_interval(spawn.fruits_cut);
`else
  assign interval = (BASE_I < FLOOR_I) ? FLOOR_I : BASE_I;
`endif

  always_comb begin
    x_new  = 10'd64 + {1'b0, lfsr[8:0]};
    vx_mag = 10'd1 + {8'd0, lfsr[11:10]};
    vx_new = (x_new < 10'd320) ? $signed(vx_mag) : -$signed(vx_mag);
    vy_new = -$signed(10'd8 + {7'd0, lfsr[14:12]});
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    if (!spawn.enable && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (spawn.enable) begin
            state_nxt = S_WAIT;
            cnt_nxt   = interval;
          end
        end
        S_WAIT: begin
          if (cnt <= 8'd1) state_nxt = S_ARMED;
          else             cnt_nxt   = cnt - 8'd1;
        end
        S_ARMED: begin
          if (!spawn.fruit_busy) begin
            state_nxt = S_LAUNCH;
            launch    = 1'b1;
          end
        end
        S_LAUNCH: begin
          state_nxt = S_WAIT;
          cnt_nxt   = interval;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      lfsr  <= LFSR_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lfsr  <= lfsr_advance(lfsr);
    end
  end

  // Launch parameters are captured from the pre-advance LFSR on the edge entering LAUNCH.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      spawn.new_fruit   <= 1'b0;
      spawn.spawn_x     <= 10'd320;
      spawn.spawn_vx    <= '0;
      spawn.spawn_vy    <= '0;
      spawn.spawn_count <= 8'd0;
    end else begin
      spawn.new_fruit <= launch;
      if (launch) begin
        spawn.spawn_x     <= x_new;
        spawn.spawn_vx    <= vx_new;
        spawn.spawn_vy    <= vy_new;
        spawn.spawn_count <= sat_inc(spawn.spawn_count);
      end
    end
  end
endmodule
